// File: rtl/regfile_pkg.sv
// Shared constants and entry type for the register array, its decoder and the write buffer.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int WB_DEPTH   = 4;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo_ctrl.sv
// Head/tail pointers, occupancy count and push/pop qualification for the write buffer.
module wb_fifo_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_req,
    input  logic                       deq_req,
    output logic                       push,
    output logic                       pop,
    output logic [$clog2(DEPTH)-1:0]   head,
    output logic [$clog2(DEPTH)-1:0]   tail,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    // Full and empty come from the count since the pointers alias when they wrap.
    always_comb begin
        full  = (count_r == CNT_DEPTH);
        empty = (count_r == {CNT_W{1'b0}});
        push  = enq_req && !full;
        pop   = deq_req && !empty;
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = head_r;
    assign tail  = tail_r;
    assign count = count_r;

endmodule

// File: rtl/regfile_write_buffer.sv
// In-order write-back buffer in front of the register array, with a youngest-match bypass lookup.
module regfile_write_buffer
    import regfile_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_data,
    input  logic                      stall,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    input  logic [ADDR_W-1:0]         lookup_addr,
    output logic                      lookup_hit,
    output logic [DATA_W-1:0]         lookup_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    logic [DEPTH-1:0]  valid_r;
    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];

    logic             enq_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [PTR_W-1:0] head_s;
    logic [PTR_W-1:0] tail_s;
    logic [PTR_W-1:0] idx_s;

    // Writes to register 0 complete the handshake but never occupy a slot.
    assign enq_s     = req_valid && (req_addr != ZERO_ADDR);
    assign req_ready = !full_s;

    wb_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .enq_req (enq_s),
        .deq_req (!stall),
        .push    (push_s),
        .pop     (pop_s),
        .head    (head_s),
        .tail    (tail_s),
        .count   (count),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Per-slot valid bits; a slot never pushes and pops on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
        end else begin
            if (pop_s) begin
                valid_r[head_s] <= 1'b0;
            end
            if (push_s) begin
                valid_r[tail_s] <= 1'b1;
            end
        end
    end

    // Entry payload storage, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_r[tail_s] <= req_addr;
            data_r[tail_s] <= req_data;
        end
    end

    // Head entry drives the array write port directly.
    always_comb begin
        wr_en = pop_s;
        if (empty_s) begin
            wr_addr = {ADDR_W{1'b0}};
            wr_data = {DATA_W{1'b0}};
        end else begin
            wr_addr = addr_r[head_s];
            wr_data = data_r[head_s];
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = {DATA_W{1'b0}};
        idx_s       = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head_s + PTR_W'(i);
            if (valid_r[idx_s] && (addr_r[idx_s] == lookup_addr) && (lookup_addr != ZERO_ADDR)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_r[idx_s];
            end else begin
                lookup_hit  = lookup_hit;
                lookup_data = lookup_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed and scoreboarded checks for regfile_write_buffer.
module tb_regfile_write_buffer;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic [31:0] req_data;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  lookup_addr;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [36:0] wlog[$];

    always #5 clk = ~clk;

    regfile_write_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .stall       (stall),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .count       (count)
    );

    // What the register array captures on each edge.
    always @(posedge clk) begin
        if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
    end

    task test_reset();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        checks++; if ({wr_addr, wr_data} !== 37'd0) begin errors++; $display("FAIL reset_wr_bus: got %h/%h expected 0/0", wr_addr, wr_data); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if ({lookup_hit, lookup_data} !== 33'd0) begin errors++; $display("FAIL reset_lookup: got %b/%h expected 0/0", lookup_hit, lookup_data); end
    endtask

    task test_single();
        wlog.delete();
        req_valid = 1'b1; req_addr = 5'd3; req_data = 32'hDEADBEEF; stall = 1'b0; lookup_addr = 5'd3;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", req_ready); end
        checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL single_lookup_excl: got %b expected 0", lookup_hit); end
        @(negedge clk); req_valid = 1'b0; #1;
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b expected 1", wr_en); end
        checks++; if (wr_addr !== 5'd3) begin errors++; $display("FAIL single_wr_addr: got %0d expected 3", wr_addr); end
        checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wr_data: got %h expected deadbeef", wr_data); end
        checks++; if (lookup_hit !== 1'b1) begin errors++; $display("FAIL single_lookup_hit: got %b expected 1", lookup_hit); end
        @(negedge clk); #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_after: got %0d expected 0", count); end
        checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL single_lookup_clear: got %b expected 0", lookup_hit); end
        checks++; if (wlog.size() !== 1 || wlog[0] !== {5'd3, 32'hDEADBEEF}) begin errors++; $display("FAIL single_log: got size %0d expected 1 entry 03/deadbeef", wlog.size()); end
    endtask

    task test_full();
        logic [4:0] exp_addr [5];
        exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        wlog.delete();
        @(negedge clk);
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1'b1; req_addr = 5'(i); req_data = 32'h100 + 32'(i);
            @(negedge clk);
        end
        req_addr = 5'd5; req_data = 32'h105; #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", req_ready); end
        @(negedge clk); #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_fifth_held: got %0d expected 4", count); end
        stall = 1'b0; #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_no_passthru: got %b expected 0", req_ready); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (wr_en !== 1'b1 || wr_addr !== exp_addr[i]) begin errors++; $display("FAIL full_drain_%0d: got en=%b addr=%0d expected en=1 addr=%0d", i, wr_en, wr_addr, exp_addr[i]); end
            if (i == 1) begin
                checks++; if (req_ready !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL full_ready_rise: got ready=%b count=%0d expected 1/3", req_ready, count); end
            end
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            #1;
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d expected 0", count); end
        checks++; if (wlog.size() !== 5) begin errors++; $display("FAIL full_log_size: got %0d expected 5", wlog.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (wlog[i] !== {5'(i + 1), 32'h101 + 32'(i)}) begin errors++; $display("FAIL full_log_%0d: got %h expected %h", i, wlog[i], {5'(i + 1), 32'h101 + 32'(i)}); end
        end
    endtask

    task test_drop_zero();
        wlog.delete();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 5'd0; req_data = 32'h1234; stall = 1'b0; lookup_addr = 5'd0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", req_ready); end
        @(negedge clk); req_valid = 1'b0; #1;
        checks++; if (count !== 3'd0 || wr_en !== 1'b0) begin errors++; $display("FAIL zero_dropped: got count=%0d en=%b expected 0/0", count, wr_en); end
        checks++; if (lookup_hit !== 1'b0 || lookup_data !== 32'd0) begin errors++; $display("FAIL zero_lookup: got %b/%h expected 0/0", lookup_hit, lookup_data); end
        @(negedge clk); #1;
        checks++; if (wlog.size() !== 0) begin errors++; $display("FAIL zero_log: got %0d writes expected 0", wlog.size()); end
    endtask

    task test_duplicate();
        wlog.delete();
        @(negedge clk);
        stall = 1'b1; lookup_addr = 5'd7;
        req_valid = 1'b1; req_addr = 5'd7; req_data = 32'hA;
        @(negedge clk); req_data = 32'hB; #1;
        checks++; if (lookup_hit !== 1'b1 || lookup_data !== 32'hA) begin errors++; $display("FAIL dup_first: got %b/%h expected 1/a", lookup_hit, lookup_data); end
        @(negedge clk); req_valid = 1'b0; #1;
        checks++; if (lookup_hit !== 1'b1 || lookup_data !== 32'hB) begin errors++; $display("FAIL dup_youngest: got %b/%h expected 1/b", lookup_hit, lookup_data); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL dup_count: got %0d expected 2", count); end
        lookup_addr = 5'd8; #1;
        checks++; if (lookup_hit !== 1'b0 || lookup_data !== 32'd0) begin errors++; $display("FAIL dup_miss: got %b/%h expected 0/0", lookup_hit, lookup_data); end
        lookup_addr = 5'd7; stall = 1'b0; #1;
        checks++; if (wr_data !== 32'hA) begin errors++; $display("FAIL dup_drain_a: got %h expected a", wr_data); end
        @(negedge clk); #1;
        checks++; if (wr_data !== 32'hB || lookup_hit !== 1'b1 || lookup_data !== 32'hB) begin errors++; $display("FAIL dup_drain_b: got wr=%h hit=%b data=%h expected b/1/b", wr_data, lookup_hit, lookup_data); end
        @(negedge clk); #1;
        checks++; if (lookup_hit !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL dup_clear: got hit=%b en=%b expected 0/0", lookup_hit, wr_en); end
        checks++; if (wlog.size() !== 2 || wlog[0] !== {5'd7, 32'hA} || wlog[1] !== {5'd7, 32'hB}) begin errors++; $display("FAIL dup_order: got size %0d expected 07/a then 07/b", wlog.size()); end
    endtask

    task test_back_to_back();
        logic [36:0] expq[$];
        int exp_count;
        int guard;
        logic acc;
        logic pop;
        wlog.delete();
        @(negedge clk);
        stall = 1'b1; req_valid = 1'b1; req_addr = 5'd9; req_data = 32'h909;
        @(negedge clk); req_addr = 5'd10; req_data = 32'h90A;
        @(negedge clk); stall = 1'b0; req_addr = 5'd11; req_data = 32'h90B; #1;
        checks++; if (count !== 3'd2 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_pre: got count=%0d ready=%b expected 2/1", count, req_ready); end
        @(negedge clk); req_valid = 1'b0; #1;
        checks++; if (count !== 3'd2 || wr_addr !== 5'd10) begin errors++; $display("FAIL b2b_count: got count=%0d head=%0d expected 2/10", count, wr_addr); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (wlog.size() !== 3 || wlog[0] !== {5'd9, 32'h909} || wlog[1] !== {5'd10, 32'h90A} || wlog[2] !== {5'd11, 32'h90B}) begin errors++; $display("FAIL b2b_order: got size %0d expected 9,10,11", wlog.size()); end

        // Random traffic against a count model and write scoreboard.
        wlog.delete();
        exp_count = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            checks++; if (count !== 3'(exp_count) || req_ready !== (exp_count < 4)) begin errors++; $display("FAIL rand_state_%0d: got count=%0d ready=%b expected %0d/%b", cyc, count, req_ready, exp_count, exp_count < 4); end
            stall     = ($urandom_range(0, 3) == 0);
            req_valid = $urandom_range(0, 1) == 1;
            req_addr  = 5'($urandom_range(0, 31));
            req_data  = $urandom;
            acc = req_valid && (exp_count < 4) && (req_addr != 5'd0);
            pop = (exp_count != 0) && !stall;
            if (acc) expq.push_back({req_addr, req_data});
            exp_count = exp_count + (acc ? 1 : 0) - (pop ? 1 : 0);
            @(negedge clk); #1;
        end
        req_valid = 1'b0; stall = 1'b0;
        guard = 0;
        while (count != 3'd0 && guard < 10) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rand_drain_timeout: got count=%0d expected 0", count); end
        checks++; if (wlog.size() !== expq.size()) begin errors++; $display("FAIL rand_log_size: got %0d expected %0d", wlog.size(), expq.size()); end
        for (int i = 0; i < expq.size(); i++) begin
            checks++; if (wlog[i] !== expq[i]) begin errors++; $display("FAIL rand_log_%0d: got %h expected %h", i, wlog[i], expq[i]); end
        end
    endtask

    task test_reset_mid();
        wlog.delete();
        @(negedge clk);
        stall = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 5'(20 + i); req_data = 32'hC00 + 32'(i);
            @(negedge clk);
        end
        req_valid = 1'b0; lookup_addr = 5'd20; #1;
        checks++; if (count !== 3'd3 || lookup_hit !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got count=%0d hit=%b expected 3/1", count, lookup_hit); end
        #2; stall = 1'b0; rst = 1'b1; #1;
        checks++; if (wr_en !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rstmid_async: got en=%b count=%0d expected 0/0", wr_en, count); end
        checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL rstmid_lookup: got %b expected 0", lookup_hit); end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (wlog.size() !== 0 || count !== 3'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_no_write: got writes=%0d count=%0d ready=%b expected 0/0/1", wlog.size(), count, req_ready); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 5'd0; req_data = 32'd0; stall = 1'b0; lookup_addr = 5'd0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_single();
        test_full();
        test_drop_zero();
        test_duplicate();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
